cache_miss_ctrl: RTL and testbench

//  Miss-handling controller between the CPU's I-cache/D-cache arrays and the single-ported unified memory.

---
 rtl/cache_miss_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - I/D-cache miss controller: arbitration, dirty writeback, line refill
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_miss, i_addr            I-cache miss request and fetch word address
//   d_miss, d_addr, d_dirty   D-cache miss request, data word address, victim dirty flag
//   d_victim_addr/line        dirty victim line address and data
//   mem_rdata, mem_rdy        memory read line and op-complete pulse
//   mem_addr, mem_re, mem_we  registered memory request
//   mem_wdata                 registered writeback data
//   fill_line, i/d_fill_we    refill data and per-cache write strobes
//   busy                      controller not idle (pipeline stall)
//   miss_cnt, wb_cnt          saturating refill / writeback counters
module cache_miss_ctrl #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_miss,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                d_miss,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_dirty,
    input  logic [ADDR_W-3:0]   d_victim_addr,
    input  logic [LINE_W-1:0]   d_victim_line,
    input  logic [LINE_W-1:0]   mem_rdata,
    input  logic                mem_rdy,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [LINE_W-1:0]   mem_wdata,
    output logic [LINE_W-1:0]   fill_line,
    output logic                i_fill_we,
    output logic                d_fill_we,
    output logic                busy,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                owner_d_q, owner_d_d;   // 1: D-cache owns the refill, 0: I-cache
    logic [ADDR_W-3:0]   line_addr_q, line_addr_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;
    logic                i_fill_we_q, i_fill_we_d;
    logic                d_fill_we_q, d_fill_we_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;

    // Word-offset bits select a word inside the line; the controller only moves whole lines.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        line_addr_d = line_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        fill_line_d = fill_line_q;
        i_fill_we_d = 1'b0;
        d_fill_we_d = 1'b0;
        miss_cnt_d  = miss_cnt_q;
        wb_cnt_d    = wb_cnt_q;

        case (state_q)
            S_IDLE: begin
                // D wins ties; I cannot starve since D cannot re-miss until the pipeline advances.
                if (d_miss) begin
                    owner_d_d   = 1'b1;
                    line_addr_d = d_addr[ADDR_W-1:2];
                    if (d_dirty) begin
                        state_d     = S_WB;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = d_victim_addr;
                        mem_wdata_d = d_victim_line;
                    end else begin
                        state_d    = S_RD;
                        mem_re_d   = 1'b1;
                        mem_addr_d = d_addr[ADDR_W-1:2];
                    end
                end else if (i_miss) begin
                    owner_d_d   = 1'b0;
                    line_addr_d = i_addr[ADDR_W-1:2];
                    state_d     = S_RD;
                    mem_re_d    = 1'b1;
                    mem_addr_d  = i_addr[ADDR_W-1:2];
                end
            end
            S_WB: begin
                if (mem_rdy) begin
                    state_d    = S_RD;
                    mem_we_d   = 1'b0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = line_addr_q;
                    if (wb_cnt_q != CNT_MAX) wb_cnt_d = wb_cnt_q + CNT_ONE;
                end
            end
            S_RD: begin
                if (mem_rdy) begin
                    state_d     = S_FILL;
                    mem_re_d    = 1'b0;
                    fill_line_d = mem_rdata;
                    d_fill_we_d = owner_d_q;
                    i_fill_we_d = ~owner_d_q;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
                if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_ONE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_d_q   <= 1'b1;
            line_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            fill_line_q <= '0;
            i_fill_we_q <= 1'b0;
            d_fill_we_q <= 1'b0;
            miss_cnt_q  <= '0;
            wb_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            line_addr_q <= line_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            fill_line_q <= fill_line_d;
            i_fill_we_q <= i_fill_we_d;
            d_fill_we_q <= d_fill_we_d;
            miss_cnt_q  <= miss_cnt_d;
            wb_cnt_q    <= wb_cnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_line = fill_line_q;
    assign i_fill_we = i_fill_we_q;
    assign d_fill_we = d_fill_we_q;
    assign busy      = (state_q != S_IDLE);
    assign miss_cnt  = miss_cnt_q;
    assign wb_cnt    = wb_cnt_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed self-checking bench for cache_miss_ctrl
module tb_cache_miss_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_dirty, mem_rdy;
    logic [15:0] i_addr, d_addr;
    logic [13:0] d_victim_addr;
    logic [63:0] d_victim_line, mem_rdata;

    logic [13:0] mem_addr;
    logic        mem_re, mem_we, i_fill_we, d_fill_we, busy;
    logic [63:0] mem_wdata, fill_line;
    logic [15:0] miss_cnt, wb_cnt;

    logic [13:0] s_mem_addr;
    logic        s_mem_re, s_mem_we, s_i_fill_we, s_d_fill_we, s_busy;
    logic [63:0] s_mem_wdata, s_fill_line;
    logic [1:0]  s_miss_cnt, s_wb_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.ADDR_W(16), .LINE_W(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr), .d_dirty(d_dirty),
        .d_victim_addr(d_victim_addr), .d_victim_line(d_victim_line),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .fill_line(fill_line), .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .busy(busy), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    cache_miss_ctrl #(.ADDR_W(16), .LINE_W(64), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr), .d_dirty(d_dirty),
        .d_victim_addr(d_victim_addr), .d_victim_line(d_victim_line),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .mem_addr(s_mem_addr), .mem_re(s_mem_re), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata),
        .fill_line(s_fill_line), .i_fill_we(s_i_fill_we), .d_fill_we(s_d_fill_we),
        .busy(s_busy), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: called on a negedge; waits for the request, checks it,
    // holds it for lat cycles checking stability, then pulses mem_rdy.
    // Returns on the negedge after the mem_rdy edge.
    task automatic serve(input string tag, input logic exp_we, input logic [13:0] exp_addr,
                         input logic [63:0] exp_wdata, input int exp_wait, input int lat,
                         input logic [63:0] rdata);
        int waited = 0;
        while (!(mem_re || mem_we) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_wait"}, 64'(waited), 64'(exp_wait));
        chk({tag, "_we"}, 64'(mem_we), 64'(exp_we));
        chk({tag, "_re"}, 64'(mem_re), 64'(!exp_we));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(exp_addr));
        if (exp_we) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_hold_addr"}, 64'(mem_addr), 64'(exp_addr));
            chk({tag, "_hold_req"}, 64'({mem_re, mem_we}), exp_we ? 64'd1 : 64'd2);
        end
        mem_rdy   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_rdy   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_miss = 0; d_miss = 0; d_dirty = 0; mem_rdy = 0;
        i_addr = '0; d_addr = '0; d_victim_addr = '0; d_victim_line = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req", 64'({mem_re, mem_we, i_fill_we, d_fill_we}), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_fill", fill_line, 64'd0);
        chk("rst_cnt", 64'({miss_cnt, wb_cnt}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1. clean D miss
        d_miss = 1; d_addr = 16'h1234; d_dirty = 0;
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        serve("t1_rd", 1'b0, 14'h048D, 64'd0, 0, 4, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("t1_fill_we", 64'({i_fill_we, d_fill_we}), 64'd1);
        chk("t1_fill_line", fill_line, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("t1_re_drop", 64'(mem_re), 64'd0);
        d_miss = 0;
        @(negedge clk);
        chk("t1_idle", 64'({busy, i_fill_we, d_fill_we}), 64'd0);
        chk("t1_miss_cnt", 64'(miss_cnt), 64'd1);
        chk("t1_wb_cnt", 64'(wb_cnt), 64'd0);

        // 2. dirty D miss: writeback then refill
        d_miss = 1; d_addr = 16'h2468; d_dirty = 1;
        d_victim_addr = 14'h0100; d_victim_line = 64'h1111_2222_3333_4444;
        @(negedge clk);
        serve("t2_wb", 1'b1, 14'h0100, 64'h1111_2222_3333_4444, 0, 2, 64'd0);
        chk("t2_wb_cnt", 64'(wb_cnt), 64'd1);
        serve("t2_rd", 1'b0, 14'h091A, 64'd0, 0, 3, 64'h0123_4567_89AB_CDEF);
        chk("t2_fill_we", 64'({i_fill_we, d_fill_we}), 64'd1);
        chk("t2_fill_line", fill_line, 64'h0123_4567_89AB_CDEF);
        d_miss = 0; d_dirty = 0;
        @(negedge clk);
        chk("t2_cnts", 64'({miss_cnt, wb_cnt}), {32'd0, 16'd2, 16'd1});

        // 3. simultaneous misses: D first, one idle cycle, then I
        i_miss = 1; i_addr = 16'h0ABC;
        d_miss = 1; d_addr = 16'h3000;
        @(negedge clk);
        serve("t3_d_rd", 1'b0, 14'h0C00, 64'd0, 0, 2, 64'hDDDD_0000_DDDD_0000);
        chk("t3_d_fill_we", 64'({i_fill_we, d_fill_we}), 64'd1);
        d_miss = 0;
        @(negedge clk);
        chk("t3_gap_idle", 64'(busy), 64'd0);
        @(negedge clk);
        serve("t3_i_rd", 1'b0, 14'h02AF, 64'd0, 0, 2, 64'h1111_AAAA_1111_AAAA);
        chk("t3_i_fill_we", 64'({i_fill_we, d_fill_we}), 64'd2);
        chk("t3_i_fill_line", fill_line, 64'h1111_AAAA_1111_AAAA);
        i_miss = 0;
        @(negedge clk);
        chk("t3_miss_cnt", 64'(miss_cnt), 64'd4);
        chk("t3_sat_cnt", 64'(s_miss_cnt), 64'd3);

        // 4. stray mem_rdy in IDLE
        mem_rdy = 1;
        @(negedge clk);
        mem_rdy = 0;
        chk("t4_state", 64'({busy, mem_re, mem_we, i_fill_we, d_fill_we}), 64'd0);
        @(negedge clk);
        chk("t4_still_idle", 64'({busy, i_fill_we, d_fill_we}), 64'd0);
        chk("t4_miss_cnt", 64'(miss_cnt), 64'd4);

        // 6. fifth refill: 16-bit counter keeps counting, 2-bit counter holds at 3
        i_miss = 1; i_addr = 16'h0040;
        @(negedge clk);
        serve("t6_rd", 1'b0, 14'h0010, 64'd0, 0, 1, 64'h5555_5555_5555_5555);
        i_miss = 0;
        @(negedge clk);
        chk("t6_miss_cnt", 64'(miss_cnt), 64'd5);
        chk("t6_sat_cnt", 64'(s_miss_cnt), 64'd3);
        chk("t6_sat_wb", 64'(s_wb_cnt), 64'd1);

        // 5. reset during RD, then a normal I refill
        i_miss = 1; i_addr = 16'h0100;
        @(negedge clk);
        chk("t5_in_rd", 64'({busy, mem_re}), 64'd3);
        rst = 1;
        @(negedge clk);
        chk("t5_rst_req", 64'({busy, mem_re, mem_we, i_fill_we, d_fill_we}), 64'd0);
        chk("t5_rst_cnt", 64'({miss_cnt, wb_cnt}), 64'd0);
        chk("t5_rst_sat", 64'({s_miss_cnt, s_wb_cnt}), 64'd0);
        rst = 0;
        @(negedge clk);
        serve("t5_rd", 1'b0, 14'h0040, 64'd0, 0, 2, 64'h7777_8888_9999_AAAA);
        chk("t5_fill_we", 64'({i_fill_we, d_fill_we}), 64'd2);
        chk("t5_fill_line", fill_line, 64'h7777_8888_9999_AAAA);
        i_miss = 0;
        @(negedge clk);
        chk("t5_miss_cnt", 64'(miss_cnt), 64'd1);
        chk("t5_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
